// File: rtl/pwm_audio_out.sv
// PWM audio output stage: 2-entry sample buffer feeding one fixed-length PWM
// frame per sample, with a pop-free power-up ramp to midscale, mute and underrun.
//
// state   | meaning
// RAMP    | after reset, duty climbs by one per frame up to MID
// RUN     | one buffered sample loaded per frame; empty buffer flags underrun
// MUTE    | duty held at MID, buffered samples drained and discarded
module pwm_audio_out #(
  parameter int W        = 8,
  parameter int PRESCALE = 1
) (
  input  logic         clock_15,
  input  logic         rst,
  input  logic [W-1:0] sample_in,
  input  logic         sample_valid,
  output logic         sample_ready,
  input  logic         mute,
  input  logic         clr_underrun,
  output logic         pwm_out,
  output logic         underrun,
  output logic         frame_start
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [W-1:0]  CNT_LAST = {W{1'b1}};
  localparam logic [W-1:0]  MID      = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_RAMP = 2'd0,
    ST_RUN  = 2'd1,
    ST_MUTE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre;
  logic [W-1:0]  cnt;
  logic [W-1:0]  duty, duty_nxt;
  logic [W-1:0]  buf_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    buf_cnt;
  logic          has_data;
  logic [W-1:0]  head;
  logic          tick, boundary, push, pop, pop_req, set_underrun;

  assign tick         = (pre == PRE_LAST);
  assign boundary     = tick && (cnt == CNT_LAST);
  assign sample_ready = (buf_cnt != 2'd2);
  assign has_data     = (buf_cnt != 2'd0);
  assign head         = buf_mem[rd_ptr];
  assign push         = sample_valid && sample_ready;
  assign pop          = pop_req && has_data;

  always_ff @(posedge clock_15) begin
    if (rst) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick) begin
      pre <= '0;
      cnt <= cnt + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clock_15) begin
    if (push) buf_mem[wr_ptr] <= sample_in;
  end

  // Push and pop never both touch an empty or full buffer, so the count
  // arithmetic cannot wrap.
  always_ff @(posedge clock_15) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock_15) begin
    if (rst) state <= ST_RAMP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (boundary) begin
      unique case (state)
        ST_RAMP: if (duty + 1'b1 == MID) state_nxt = ST_RUN;
        ST_RUN:  if (mute)               state_nxt = ST_MUTE;
        ST_MUTE: if (!mute)              state_nxt = ST_RUN;
        default:                         state_nxt = ST_RAMP;
      endcase
    end
  end

  always_comb begin
    duty_nxt     = duty;
    pop_req      = 1'b0;
    set_underrun = 1'b0;
    if (boundary) begin
      unique case (state)
        ST_RAMP: duty_nxt = duty + 1'b1;
        ST_RUN: begin
          pop_req = 1'b1;
          if (mute)          duty_nxt     = MID;
          else if (has_data) duty_nxt     = head;
          else               set_underrun = 1'b1;
        end
        ST_MUTE: begin
          pop_req  = 1'b1;
          duty_nxt = (!mute && has_data) ? head : MID;
        end
        default: duty_nxt = '0;
      endcase
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clock_15) begin
    if (rst) begin
      duty        <= '0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      duty        <= duty_nxt;
      pwm_out     <= (cnt < duty);
      frame_start <= boundary;
      if (set_underrun)      underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: frame-level reference model (sample queue, ramp
// index, mute flag) checked against per-frame high counts and status outputs.
module tb_pwm_audio_out;

  localparam int MID = 8;

  logic       clock_15 = 1'b0;
  logic       rst = 1'b1, sample_valid = 1'b0, mute = 1'b0, clr_underrun = 1'b0;
  logic [3:0] sample_in = 4'd0;
  logic       sample_ready, pwm_out, underrun, frame_start;

  logic       rst3 = 1'b1, sample_valid3 = 1'b0, mute3 = 1'b0, clr3 = 1'b0;
  logic [3:0] sample_in3 = 4'd0;
  logic       sample_ready3, pwm3, underrun3, fs3;

  always #5 clock_15 = ~clock_15;

  pwm_audio_out #(.W(4), .PRESCALE(1)) dut (
    .clock_15(clock_15), .rst(rst), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .mute(mute),
    .clr_underrun(clr_underrun), .pwm_out(pwm_out), .underrun(underrun),
    .frame_start(frame_start)
  );

  pwm_audio_out #(.W(4), .PRESCALE(3)) dut3 (
    .clock_15(clock_15), .rst(rst3), .sample_in(sample_in3),
    .sample_valid(sample_valid3), .sample_ready(sample_ready3), .mute(mute3),
    .clr_underrun(clr3), .pwm_out(pwm3), .underrun(underrun3),
    .frame_start(fs3)
  );

  int   errors = 0;
  int   checks = 0;
  int   m_q[$];
  int   m_duty, m_n;
  bit   m_inmute;
  logic m_underrun;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_duty     = 0;
    m_n        = 0;
    m_inmute   = 1'b0;
    m_underrun = 1'b0;
  endtask

  // One frame boundary: the first MID boundaries ramp, after that the queue
  // and mute decide the duty.
  task automatic model_boundary(input bit mute_v);
    int  v;
    bit  have;
    m_n++;
    if (m_n <= MID) begin
      m_duty = m_n;
    end else if (!m_inmute) begin
      if (mute_v) begin
        if (m_q.size() > 0) v = m_q.pop_front();
        m_duty   = MID;
        m_inmute = 1'b1;
      end else if (m_q.size() > 0) begin
        m_duty = m_q.pop_front();
      end else begin
        m_underrun = 1'b1;
      end
    end else begin
      have = (m_q.size() > 0);
      if (have) v = m_q.pop_front();
      if (!mute_v) begin
        m_inmute = 1'b0;
        if (have) m_duty = v;
      end
    end
  endtask

  // Single-cycle reset; returns at the negedge of the first post-reset cycle.
  task automatic do_reset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    mute         = 1'b0;
    clr_underrun = 1'b0;
    @(negedge clock_15);
    chk("rst_pwm_out", pwm_out, 0);
    chk("rst_sample_ready", sample_ready, 1);
    chk("rst_underrun", underrun, 0);
    chk("rst_frame_start", frame_start, 0);
    rst = 1'b0;
    model_reset();
  endtask

  // Entered at the negedge of a cnt=0 cycle; returns at the next one.
  task automatic run_frame(input int np, input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input bit mute_v, input bit clr_v);
    logic [3:0] d [3];
    int highs, fs;
    d[0] = d0; d[1] = d1; d[2] = d2;
    highs = 0;
    fs = 0;
    mute = mute_v;
    clr_underrun = clr_v;
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i < np)
        chk($sformatf("ready_f%0d_c%0d", m_n, i), sample_ready, (m_q.size() < 2));
      if (i < np) begin
        sample_valid = 1'b1;
        sample_in    = d[i];
        if (m_q.size() < 2) m_q.push_back(int'(d[i]));
      end else begin
        sample_valid = 1'b0;
      end
      @(negedge clock_15);
      if (i == 0) begin
        clr_underrun = 1'b0;
        if (clr_v) m_underrun = 1'b0;
        chk($sformatf("underrun_early_f%0d", m_n), underrun, m_underrun);
      end
      highs += int'(pwm_out);
      fs    += int'(frame_start);
    end
    sample_valid = 1'b0;
    chk($sformatf("highs_f%0d", m_n), highs, m_duty);
    chk($sformatf("fs_count_f%0d", m_n), fs, 1);
    chk($sformatf("fs_at_end_f%0d", m_n), frame_start, 1);
    model_boundary(mute_v);
    chk($sformatf("underrun_f%0d", m_n), underrun, m_underrun);
  endtask

  initial begin
    int seen, highs, fs;

    // PRESCALE=3 instance: one sample pushed during its ramp, measured at the end.
    @(negedge clock_15);
    rst3 = 1'b0;
    sample_valid3 = 1'b1;
    sample_in3 = 4'd5;
    @(negedge clock_15);
    sample_valid3 = 1'b0;

    // Ramp with no samples, then underrun and clear.
    do_reset();
    for (int f = 0; f < 9; f++) run_frame(0, 0, 0, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0, 1);

    // Buffer fill during ramp, third push blocked; extremes; mute.
    do_reset();
    run_frame(3, 4'd3, 4'd12, 4'd6, 0, 0);
    for (int f = 1; f < 11; f++) run_frame(0, 0, 0, 0, 0, 0);
    run_frame(1, 4'd0, 0, 0, 0, 0);
    run_frame(1, 4'd15, 0, 0, 0, 0);
    run_frame(1, 4'd5, 0, 0, 1, 1);
    run_frame(1, 4'd7, 0, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int f = 0; f < 40; f++) begin
      run_frame($urandom_range(0, 3), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0));
    end

    // Mid-frame reset with a full buffer and underrun set.
    for (int f = 0; f < 4; f++) run_frame(0, 0, 0, 0, 0, 0);
    chk("pre_reset_underrun", underrun, 1);
    chk("pre_reset_ready", sample_ready, 1);
    sample_valid = 1'b1;
    sample_in = 4'd9;
    @(negedge clock_15);
    sample_in = 4'd13;
    @(negedge clock_15);
    sample_valid = 1'b0;
    chk("full_ready", sample_ready, 0);
    repeat (3) @(negedge clock_15);
    do_reset();
    for (int f = 0; f < 10; f++) run_frame(0, 0, 0, 0, 0, 0);

    // PRESCALE=3: 48-cycle frames, duty 5 gives 15 high cycles.
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clock_15);
      if (fs3) seen = 1;
    end
    chk("p3_fs_seen", seen, 1);
    for (int f = 0; f < 2; f++) begin
      highs = 0;
      fs = 0;
      for (int i = 0; i < 48; i++) begin
        @(negedge clock_15);
        highs += int'(pwm3);
        fs    += int'(fs3);
      end
      chk("p3_highs", highs, 15);
      chk("p3_fs_count", fs, 1);
      chk("p3_fs_at_end", fs3, 1);
    end
    chk("p3_underrun", underrun3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_audio_out.md
# pwm_audio_out

Sound-board output stage directly downstream of the POKEY wrapper. It accepts audio samples over a valid/ready handshake into a 2-entry buffer and converts each sample into one fixed-length PWM frame on a single output pin. On reset it ramps the duty up to midscale so the output does not pop. It also supports muting and flags underruns.

## Interface
- W, default 8: sample width; the PWM frame is 2^W counts; MID = 2^(W-1).
- PRESCALE, default 1: clock_15 cycles per PWM count; must be 1 or more.

- clock_15  in  1  system clock; all logic is single-domain on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- sample_in  in  W  unsigned duty value.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  buffer can accept a sample; equals "buffer not full".
- mute  in  1  request to hold the output at midscale.
- clr_underrun  in  1  one-cycle pulse that clears underrun.
- pwm_out  out  1  registered PWM output.
- underrun  out  1  sticky flag for an underrun.
- frame_start  out  1  one-cycle pulse at the start of each frame.

## Operation
- Prescaler pre counts 0..PRESCALE-1. tick = (pre == PRESCALE-1).
- Frame counter cnt is W bits and advances on tick, wrapping from 2^W-1 to 0.
- A boundary is a cycle where tick && cnt == 2^W-1. The duty, buffer pop and state all update on the clock edge that ends the boundary cycle.
- Each cycle, pwm_out <= (cnt < duty), unsigned compare.
  - duty = 0 gives a constant 0.
  - duty = 2^W-1 gives high for 2^W-1 of 2^W counts.
- Buffer: 2-entry FIFO.
  - A push occurs on sample_valid && sample_ready.
  - A pop occurs only at a boundary in RUN or MUTE.
  - Push and pop in the same cycle with 1 entry: the count stays 1, and the popped entry is the older one.
  - No push is possible while full.
- State machine:
  - RAMP (entered on reset): at each boundary, duty <= duty+1. If duty+1 == MID, the next state is RUN. No pop occurs; pushes are accepted.
  - RUN: at each boundary, the action depends on mute and the buffer:
    - mute = 1: pop and discard any entry, duty <= MID, next state MUTE.
    - mute = 0, buffer non-empty: duty <= popped sample.
    - mute = 0, buffer empty: duty is held and underrun <= 1.
  - MUTE: at each boundary, pop and discard any entry; duty stays MID; underrun is never set. If mute = 0 at the boundary, the next state is RUN and the popped sample, if any, is loaded as duty.
- underrun is set only as above. It is cleared by clr_underrun or rst. If set and clear coincide, set wins.
- frame_start is registered: it is high in the cycle after a boundary, i.e. when cnt = 0 with the new duty in effect.

## Timing
- Reset values: pre = 0, cnt = 0, duty = 0, state RAMP, buffer empty.
- Output reset values: pwm_out = 0, sample_ready = 1, underrun = 0, frame_start = 0.
- rst asserted at any time, including mid-frame or mid-ramp, restores all reset values on the next edge. Buffer contents are discarded and the ramp restarts from duty 0.
- pwm_out latency is 1 cycle from cnt/duty. A new duty first affects the pwm_out value sampled during the cnt = 0 cycle.
- Frame length is PRESCALE × 2^W cycles. The ramp lasts MID frames, so the first sample is consumed at boundary MID+1 after reset.
- sample_ready is combinational from the buffer count. It deasserts the cycle after the push that fills the buffer and reasserts the cycle after a pop from full.
- mute and clr_underrun are sampled only as stated; mute is effective only at boundaries.

## Test plan
- Reset ramp (W=4, P=1, no samples):
  - Per-frame high count is 0,1,…,8 over boundaries 1–8, then the state is RUN.
  - Boundary 9 sets underrun = 1 with duty held at 8 highs of 16.
  - clr_underrun then gives underrun = 0.
- Buffer fill (W=4, P=1):
  - During the ramp, push 3 and then 12; a third valid is blocked with sample_ready = 0.
  - Boundary 9 gives duty 3 and sample_ready = 1 on the next cycle.
  - Boundary 10 gives duty 12; boundary 11 sets underrun.
- Extremes (W=4, P=1): sample 0 gives pwm_out = 0 for all 16 cycles; sample 15 gives 15 high cycles and 1 low.
- Mute (W=4, P=1):
  - In RUN with 5 buffered, assert mute before the boundary: duty becomes 8, the 5 is discarded, underrun stays 0.
  - Deassert mute with 7 buffered: the next boundary gives duty 7.
- Prescale (W=4, PRESCALE=3): frame is 48 cycles; duty 5 gives 15 high cycles; frame_start pulses every 48 cycles.
- Mid-run reset with the buffer full: a 1-cycle rst gives pwm_out = 0, sample_ready = 1, underrun = 0, and the ramp restarts at duty 0 with no stale sample ever output.
